reg_wr_sched: RTL
=================

# reg_wr_sched

Write scheduler for a shared bank of N-bit registers. Up to NREQ requesters compete for write access. A round-robin arbiter with optional burst locking grants one requester per cycle. The accepted beat passes through a one-stage write pipeline into the bank, and the bank has one combinational read port for downstream datapath logic.

## Interface
- N, 16: data width of each register
- NREQ, 4: number of write requesters (2..8)
- AW, 3: register address width; bank depth NREG = 2**AW (localparam)
- MAX_BURST, 4: max beats one owner may hold a locked grant (1..15)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester write beat valid
- req_lock  in  NREQ  per-requester "keep grant after this beat"
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_data  in  NREQ*N  packed data, requester i at [i*N +: N]
- req_ready  out  NREQ  one-hot or zero; beat of i accepted when req_valid[i] & req_ready[i]
- rd_addr  in  AW  read address
- rd_data  out  N  combinational bank[rd_addr]
- grant_vld  out  1  FSM in OWN state
- grant_id  out  3  current owner index (0 when not in OWN)
- wr_busy  out  1  write stage holds a pending write

## Operation
- FSM states IDLE and OWN. Registered state: state, owner, rr_ptr, burst_cnt (4 b), stage {vld, addr, data}, bank.
- IDLE: if any req_valid, the winner is the first valid index scanning rr_ptr, rr_ptr+1, … modulo NREQ. req_ready[winner]=1 in the same cycle, and the beat is accepted.
  - If req_lock[winner]=1 and MAX_BURST>1, go to OWN with owner=winner and burst_cnt=1.
  - Otherwise stay IDLE with rr_ptr=winner+1 (wrap NREQ-1→0).
- OWN: only req_ready[owner] may be 1, and it equals req_valid[owner]. All other requesters are stalled.
  - Owner beat with lock=0: accepted, release.
  - Owner beat with burst_cnt+1==MAX_BURST: accepted, forced release regardless of lock.
  - Owner beat otherwise: accepted, burst_cnt+1.
  - req_valid[owner]=0: release with no beat, and req_ready[owner]=0 that cycle.
  - Release means next state is IDLE, rr_ptr=owner+1, burst_cnt=0.
- Write pipeline: an accepted beat loads the stage at that edge (stage.vld=1). At the next edge, bank[stage.addr]<=stage.data. With no accepted beat, stage.vld<=0.
- Back-to-back beats to the same address: the later beat wins. No merging.
- Read: rd_data is the bank only. There is no bypass from the stage, so a read of an address being written returns the old value until the bank updates.
- rst_n=0 at an edge does the following:
  - All bank entries, stage, rr_ptr, burst_cnt and owner go to 0; state goes to IDLE.
  - A pending stage write is discarded.
  - While rst_n=0, req_ready=0 combinationally.
- Reset values: req_ready=0, grant_vld=0, grant_id=0, wr_busy=0, rd_data=0.

## Timing
- Grant is combinational: at most one arbitration cycle and zero bubble cycles between beats.
- Write latency: beat accepted at edge t, stage valid during cycle t+1, bank updated at edge t+1, rd_data shows the new value from cycle t+2.
- After a release in cycle t, arbitration resumes in cycle t+1 with the updated rr_ptr. This gives a one-cycle IDLE turnaround even when the same owner still requests.
- Sustained throughput: one write per cycle.
- Fairness: a continuously valid requester waits at most (NREQ-1)*MAX_BURST accepted beats, plus the turnaround cycles.

## Structure
- Shared package reg_wr_pkg holds:
  - the state enum (ST_IDLE=1'b0, ST_OWN=1'b1)
  - the stage struct {vld, addr, data}
  - the grant index width constant (3)
- Sub-module reg_wr_rr_pick is purely combinational. It takes a valid vector and a ptr and returns any_vld and winner index.
- FSM, stage and bank stay in the top.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → req_ready=0, rd_data=0 for every rd_addr. Release reset → requester 0 granted first.
- Round-robin: all four valid, lock=0, addr=i, data=16'hA0+i for 8 cycles → accept order 0,1,2,3,0,1,2,3. bank[i]=16'hA0+i two cycles after the last beat.
- Burst:
  - req 2 locks with valid every cycle, others valid → 4 consecutive beats from req 2 (forced release at MAX_BURST=4), then one IDLE cycle, then req 3 is granted.
  - Req 2 drops valid after 2 beats → release, no third beat.
- Write latency and no-bypass: req 1 writes addr 5 = 16'h1234 at edge t with rd_addr=5 → rd_data=old value in cycle t+1 and 16'h1234 in cycle t+2.
- Same address collision: req 0 writes addr 3 = 16'h0001, then req 1 writes addr 3 = 16'h0002 the next cycle → final bank[3]=16'h0002.
- Reset mid-operation: assert rst_n=0 for one edge while in OWN with stage valid → no bank write occurs, state IDLE, grant_vld=0, and rr_ptr restarts at 0.

Source files
------------

// File: rtl/reg_wr_pkg.sv
// Shared types for the register write scheduler: FSM states, write stage record,
// grant index width and the round-robin pointer advance helper.
package reg_wr_pkg;

  localparam int unsigned GRANT_W      = 3;
  localparam int unsigned STAGE_AW_MAX = 8;
  localparam int unsigned STAGE_DW_MAX = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Sized for the widest supported bank; narrower instances zero-extend into it.
  typedef struct packed {
    logic                    vld;
    logic [STAGE_AW_MAX-1:0] addr;
    logic [STAGE_DW_MAX-1:0] data;
  } stage_t;

  function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] idx,
                                                  input int unsigned nreq);
    return (32'(idx) == nreq - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/reg_wr_rr_pick.sv
// Combinational round-robin picker: first valid index scanning from ptr upward,
// wrapping modulo NREQ.
module reg_wr_rr_pick
  import reg_wr_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]    vld,
  input  logic [GRANT_W-1:0] ptr,
  output logic               any_vld,
  output logic [GRANT_W-1:0] winner
);

  int unsigned idx;

  always_comb begin
    any_vld = |vld;
    winner  = '0;
    idx     = 0;
    // Scan from the far end back to ptr so the closest valid index is written last.
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (i == idx && vld[i]) winner = GRANT_W'(i);
      end
    end
  end

endmodule

// File: rtl/reg_wr_sched.sv
// Round-robin write scheduler with burst locking, one-stage write pipeline and
// a register bank with a single combinational read port.
module reg_wr_sched
  import reg_wr_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*N-1:0]  req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic [AW-1:0]      rd_addr,
  output logic [N-1:0]       rd_data,
  output logic               grant_vld,
  output logic [2:0]         grant_id,
  output logic               wr_busy
);

  localparam int unsigned NREG = 2 ** AW;

  state_t             state, state_n;
  logic [GRANT_W-1:0] owner, owner_n;
  logic [GRANT_W-1:0] rr_ptr, rr_ptr_n;
  logic [3:0]         burst_cnt, burst_cnt_n;
  stage_t             stage, stage_n;
  logic [N-1:0]       bank [NREG];

  logic               any_vld;
  logic [GRANT_W-1:0] winner;
  logic [NREQ-1:0]    win_oh, own_oh, acc_oh;

  reg_wr_rr_pick #(.NREQ(NREQ)) u_pick (
    .vld     (req_valid),
    .ptr     (rr_ptr),
    .any_vld (any_vld),
    .winner  (winner)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      win_oh[i] = (winner == GRANT_W'(i));
      own_oh[i] = (owner  == GRANT_W'(i));
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    acc_oh      = '0;
    unique case (state)
      ST_IDLE: begin
        if (any_vld) begin
          acc_oh = win_oh;
          if (|(req_lock & win_oh) && MAX_BURST > 1) begin
            state_n     = ST_OWN;
            owner_n     = winner;
            burst_cnt_n = 4'd1;
          end else begin
            rr_ptr_n = next_idx(winner, NREQ);
          end
        end
      end
      ST_OWN: begin
        if (|(req_valid & own_oh)) begin
          acc_oh      = own_oh;
          burst_cnt_n = burst_cnt + 4'd1;
        end
        if (!(|(req_valid & own_oh)) || !(|(req_lock & own_oh)) ||
            (burst_cnt + 4'd1) == 4'(MAX_BURST)) begin
          state_n     = ST_IDLE;
          rr_ptr_n    = next_idx(owner, NREQ);
          burst_cnt_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (!rst_n) acc_oh = '0;
  end

  always_comb begin
    stage_n = '0;
    if (|acc_oh) begin
      stage_n.vld = 1'b1;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (acc_oh[i]) begin
          stage_n.addr = STAGE_AW_MAX'(req_addr[i*AW +: AW]);
          stage_n.data = STAGE_DW_MAX'(req_data[i*N +: N]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      stage     <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
      stage     <= stage_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!rst_n)
        bank[i] <= '0;
      else if (stage.vld && stage.addr == STAGE_AW_MAX'(i))
        bank[i] <= N'(stage.data);
    end
  end

  assign req_ready = acc_oh;
  assign rd_data   = bank[rd_addr];
  assign grant_vld = (state == ST_OWN);
  assign grant_id  = (state == ST_OWN) ? owner : 3'd0;
  assign wr_busy   = stage.vld;

endmodule
